fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined RV32I core.
- Holds the architectural PC register (PCF) and produces PCPlus4F for the next-PC select logic.
- Loads the selected next PC (PCNext) every unstalled cycle.
- Registers the fetched instruction and its PCs into the IF/ID pipeline register, with stall and flush control from the hazard unit.

---
 rtl/core_pkg.sv | 25 ++
 rtl/fetch_stage_if.sv | 45 ++++
 rtl/if_id_reg.sv | 46 ++++
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared fetch-side constants, the IF/ID pipeline record and PC helpers.
package core_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
    logic            misalign;
  } if_id_t;

  // Instruction fetch is word-granular; the low two bits are dropped.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle; StallCntF/FlushCntD exist only with FETCH_PERF_CNT_EN.
interface fetch_stage_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] PCNext;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic [31:0]      InstrF;
  logic [WIDTH-1:0] PCF;
  logic [WIDTH-1:0] PCPlus4F;
  logic [31:0]      InstrD;
  logic [WIDTH-1:0] PCD;
  logic [WIDTH-1:0] PCPlus4D;
  logic             ValidD;
  logic             MisalignD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]      StallCntF;
  logic [31:0]      FlushCntD;
`endif

`ifdef FETCH_PERF_CNT_EN
  modport master (
    output PCNext, StallF, StallD, FlushD, InstrF,
    input  PCF, PCPlus4F, InstrD, PCD, PCPlus4D, ValidD, MisalignD,
    input  StallCntF, FlushCntD
  );
  modport slave (
    input  PCNext, StallF, StallD, FlushD, InstrF,
    output PCF, PCPlus4F, InstrD, PCD, PCPlus4D, ValidD, MisalignD,
    output StallCntF, FlushCntD
  );
`else
  modport master (
    output PCNext, StallF, StallD, FlushD, InstrF,
    input  PCF, PCPlus4F, InstrD, PCD, PCPlus4D, ValidD, MisalignD
  );
  modport slave (
    input  PCNext, StallF, StallD, FlushD, InstrF,
    output PCF, PCPlus4F, InstrD, PCD, PCPlus4D, ValidD, MisalignD
  );
`endif

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble and beats stall; stall holds.
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t fetch_i,
  output if_id_t decode_o
);

  if_id_t ifid_d;
  if_id_t ifid_q;

  always_comb begin
    ifid_d = ifid_q;
    if (flush) begin
      // Bubble still carries the squashed PC so the slot is traceable.
      ifid_d.instr    = NOP;
      ifid_d.pc       = fetch_i.pc;
      ifid_d.pc_plus4 = fetch_i.pc_plus4;
      ifid_d.valid    = 1'b0;
      ifid_d.misalign = 1'b0;
    end else if (!stall) begin
      ifid_d = fetch_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q.instr    <= NOP;
      ifid_q.pc       <= '0;
      ifid_q.pc_plus4 <= '0;
      ifid_q.valid    <= 1'b0;
      ifid_q.misalign <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign decode_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, +4 adder and IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
  import core_pkg::*;
#(
  parameter int          WIDTH     = XLEN,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.slave fif
);

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;
  logic             misalign_d;
  logic             misalign_q;
  logic [WIDTH-1:0] pc_plus4;
  if_id_t           fetch_rec;
  if_id_t           decode_rec;

  assign pc_plus4 = pc_q + WIDTH'(4);

  // The misalign flag rides with PCF so it reaches IF/ID with its instruction.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (!fif.StallF) begin
      pc_d       = pc_align(fif.PCNext);
      misalign_d = pc_misaligned(fif.PCNext);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    fetch_rec          = '0;
    fetch_rec.instr    = fif.InstrF;
    fetch_rec.pc       = pc_q;
    fetch_rec.pc_plus4 = pc_plus4;
    fetch_rec.valid    = 1'b1;
    fetch_rec.misalign = misalign_q;
  end

  if_id_reg #(
    .NOP (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .stall    (fif.StallD),
    .flush    (fif.FlushD),
    .fetch_i  (fetch_rec),
    .decode_o (decode_rec)
  );

  assign fif.PCF       = pc_q;
  assign fif.PCPlus4F  = pc_plus4;
  assign fif.InstrD    = decode_rec.instr;
  assign fif.PCD       = decode_rec.pc;
  assign fif.PCPlus4D  = decode_rec.pc_plus4;
  assign fif.ValidD    = decode_rec.valid;
  assign fif.MisalignD = decode_rec.misalign;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_d;
  logic [31:0] flush_cnt_q;

  // Both counters wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fif.StallF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (fif.FlushD) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fif.StallCntF = stall_cnt_q;
  assign fif.FlushCntD = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns 32'hA0 + PCF.
module tb_fetch_stage;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  fetch_stage_if #(.WIDTH(32)) fif ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  assign fif.InstrF = 32'h0000_00A0 + fif.PCF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    fif.PCNext = 32'h0;
    fif.StallF = 1'b0;
    fif.StallD = 1'b0;
    fif.FlushD = 1'b0;

    #12;
    rst = 1'b0;
    fif.PCNext = 32'h4;
    step();
    fif.PCNext = 32'h8;
    step();
    check("pre_rst_pcf", fif.PCF, 32'h8);

    // Reset asserted mid-cycle while stall and flush are active
    fif.StallF = 1'b1;
    fif.FlushD = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_pcf", fif.PCF, 32'h0);
    check("rst_validd", {31'b0, fif.ValidD}, 32'h0);
    check("rst_instrd", fif.InstrD, 32'h13);
    check("rst_pcd", fif.PCD, 32'h0);
    check("rst_pcplus4d", fif.PCPlus4D, 32'h0);
    check("rst_misaligned", {31'b0, fif.MisalignD}, 32'h0);
    check("rst_pcplus4f", fif.PCPlus4F, 32'h4);
    #1;
    rst = 1'b0;
    fif.StallF = 1'b0;
    fif.FlushD = 1'b0;
    fif.PCNext = 32'h4;

    // First fetch after reset
    step();
    check("f1_pcf", fif.PCF, 32'h4);
    check("f1_instrd", fif.InstrD, 32'hA0);
    check("f1_pcd", fif.PCD, 32'h0);
    check("f1_pcplus4d", fif.PCPlus4D, 32'h4);
    check("f1_validd", {31'b0, fif.ValidD}, 32'h1);
    check("f1_pcplus4f", fif.PCPlus4F, 32'h8);

    fif.PCNext = 32'h8;
    step();
    check("f2_pcf", fif.PCF, 32'h8);
    check("f2_instrd", fif.InstrD, 32'hA4);
    check("f2_pcd", fif.PCD, 32'h4);

    // Two-cycle full stall at PCF=8
    fif.StallF = 1'b1;
    fif.StallD = 1'b1;
    fif.PCNext = 32'hC;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_pcf", fif.PCF, 32'h8);
      check("stall_instrd", fif.InstrD, 32'hA4);
      check("stall_pcd", fif.PCD, 32'h4);
    end
    fif.StallF = 1'b0;
    fif.StallD = 1'b0;
    step();
    check("unstall_pcf", fif.PCF, 32'hC);
    check("unstall_instrd", fif.InstrD, 32'hA8);
    check("unstall_pcd", fif.PCD, 32'h8);

    // Taken jump: wrong-path slot becomes a bubble
    fif.PCNext = 32'h100;
    fif.FlushD = 1'b1;
    step();
    check("jmp_pcf", fif.PCF, 32'h100);
    check("jmp_validd", {31'b0, fif.ValidD}, 32'h0);
    check("jmp_instrd", fif.InstrD, 32'h13);
    check("jmp_pcd", fif.PCD, 32'hC);
    check("jmp_pcplus4d", fif.PCPlus4D, 32'h10);
    fif.FlushD = 1'b0;
    fif.PCNext = 32'h104;
    step();
    check("tgt_validd", {31'b0, fif.ValidD}, 32'h1);
    check("tgt_pcd", fif.PCD, 32'h100);
    check("tgt_instrd", fif.InstrD, 32'h1A0);
    check("tgt_pcplus4d", fif.PCPlus4D, 32'h104);

    // Flush beats stall; misaligned next PC
    fif.FlushD = 1'b1;
    fif.StallD = 1'b1;
    fif.PCNext = 32'h102;
    step();
    check("fbs_validd", {31'b0, fif.ValidD}, 32'h0);
    check("fbs_instrd", fif.InstrD, 32'h13);
    check("fbs_pcd", fif.PCD, 32'h104);
    check("mis_pcf", fif.PCF, 32'h100);
    check("fbs_misaligned", {31'b0, fif.MisalignD}, 32'h0);
    fif.FlushD = 1'b0;
    fif.StallD = 1'b0;
    fif.PCNext = 32'h104;
    step();
    check("mis_misaligned", {31'b0, fif.MisalignD}, 32'h1);
    check("mis_pcd", fif.PCD, 32'h100);
    check("mis_instrd", fif.InstrD, 32'h1A0);

    // Wrap at the top of the address space
    fif.PCNext = 32'hFFFF_FFFC;
    step();
    check("wrap_pcf", fif.PCF, 32'hFFFF_FFFC);
    check("wrap_pcplus4f", fif.PCPlus4F, 32'h0);
    check("wrap_misaligned", {31'b0, fif.MisalignD}, 32'h0);
    check("wrap_instrd", fif.InstrD, 32'h1A4);
    fif.PCNext = 32'h0;
    step();
    check("wrap2_pcf", fif.PCF, 32'h0);
    check("wrap2_pcd", fif.PCD, 32'hFFFF_FFFC);
    check("wrap2_pcplus4d", fif.PCPlus4D, 32'h0);
    check("wrap2_instrd", fif.InstrD, 32'h9C);

    // StallF alone: PC holds, IF/ID reloads the same instruction
    fif.StallF = 1'b1;
    fif.PCNext = 32'h40;
    step();
    check("sf_pcf", fif.PCF, 32'h0);
    check("sf_instrd", fif.InstrD, 32'hA0);
    check("sf_pcd", fif.PCD, 32'h0);

    // StallD alone: PC advances, IF/ID holds
    fif.StallF = 1'b0;
    fif.StallD = 1'b1;
    step();
    check("sd_pcf", fif.PCF, 32'h40);
    check("sd_instrd", fif.InstrD, 32'hA0);
    check("sd_pcd", fif.PCD, 32'h0);
    fif.StallD = 1'b0;

`ifdef FETCH_PERF_CNT_EN
    check("perf_stallcnt", fif.StallCntF, 32'd3);
    check("perf_flushcnt", fif.FlushCntD, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
